// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter with cyc-based ownership and round-robin fairness.
// Optional stuck-slave timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  gnt_o
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   timeout_c;
    logic   stb_fwd_c;
    logic   term_c;

    assign term_c = s_ack_i | s_err_i | s_rty_i;

    always_comb begin
        stb_fwd_c = 1'b0;
        case (state_q)
            GRANT0:  stb_fwd_c = m0_cyc_i & m0_stb_i;
            GRANT1:  stb_fwd_c = m1_cyc_i & m1_stb_i;
            default: stb_fwd_c = 1'b0;
        endcase
    end

    // State and round-robin history register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: ownership is held until the owner drops cyc, then handed over without a bubble.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (m0_cyc_i)        state_d = GRANT0;
                else if (m1_cyc_i)        state_d = GRANT1;
            end
            GRANT0: begin
                if (timeout_c)      state_d = IDLE;
                else if (!m0_cyc_i) state_d = m1_cyc_i ? GRANT1 : IDLE;
            end
            GRANT1: begin
                if (timeout_c)      state_d = IDLE;
                else if (!m1_cyc_i) state_d = m0_cyc_i ? GRANT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GRANT0) last_grant_d = 1'b0;
        if (state_d == GRANT1) last_grant_d = 1'b1;
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wait_q;

    // Counts stalled strobe cycles of the current owner; any break in the wait restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == IDLE || state_d != state_q || !stb_fwd_c || term_c || timeout_c)
            wait_q <= '0;
        else
            wait_q <= wait_q + CNT_W'(1);
    end

    assign timeout_c = stb_fwd_c && !term_c && (wait_q >= CNT_W'(TIMEOUT_CYCLES));
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    // Bus steering: the owner sees the slave, everything else is held at zero.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        gnt_o    = 2'b00;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                GRANT0: begin
                    gnt_o    = 2'b01;
                    s_cyc_o  = m0_cyc_i & ~timeout_c;
                    s_stb_o  = m0_stb_i & ~timeout_c;
                    s_we_o   = m0_we_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    s_sel_o  = m0_sel_i;
                    m0_dat_o = s_dat_i;
                    m0_ack_o = s_ack_i;
                    m0_err_o = s_err_i | timeout_c;
                    m0_rty_o = s_rty_i;
                end
                GRANT1: begin
                    gnt_o    = 2'b10;
                    s_cyc_o  = m1_cyc_i & ~timeout_c;
                    s_stb_o  = m1_stb_i & ~timeout_c;
                    s_we_o   = m1_we_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    s_sel_o  = m1_sel_i;
                    m1_dat_o = s_dat_i;
                    m1_ack_o = s_ack_i;
                    m1_err_o = s_err_i | timeout_c;
                    m1_rty_o = s_rty_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m; the bench plays both masters and the slave.
module tb_wb_arbiter_2m;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_wdat, m0_rdat;
    logic [3:0]  m0_sel;
    logic        m0_ack, m0_err, m0_rty;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_wdat, m1_rdat;
    logic [3:0]  m1_sel;
    logic        m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  gnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt0, cnt1, e;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_dat_o(m0_rdat),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_dat_o(m1_rdat),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_dat_i(s_rdat),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .gnt_o(gnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        m0_adr = 32'h0; m0_wdat = 32'h0; m0_sel = 4'h0;
        m1_adr = 32'h0; m1_wdat = 32'h0; m1_sel = 4'h0;
        s_rdat = 32'h0; {s_ack, s_err, s_rty} = '0;
        step(); step();

        // Reset state, even with a request and slave activity pending
        m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1; s_rdat = 32'h1234_5678;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_m0_ack", 32'(m0_ack), 32'h0);
        chk("rst_m0_dat", m0_rdat, 32'h0);
        chk("rst_m1_ack", 32'(m1_ack), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Single m0 read of 0x100, acked one cycle after grant
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100; m0_sel = 4'hf;
        #1;
        chk("t1_pre_gnt", 32'(gnt), 32'h0);
        chk("t1_pre_scyc", 32'(s_cyc), 32'h0);
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_s_cyc", 32'(s_cyc), 32'h1);
        chk("t1_s_stb", 32'(s_stb), 32'h1);
        chk("t1_s_adr", s_adr, 32'h100);
        chk("t1_s_sel", 32'(s_sel), 32'hf);
        s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        #1;
        chk("t1_m0_ack", 32'(m0_ack), 32'h1);
        chk("t1_m0_dat", m0_rdat, 32'hDEAD_BEEF);
        chk("t1_m1_ack", 32'(m1_ack), 32'h0);
        chk("t1_m1_dat", m1_rdat, 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        step();
        chk("t1_release", 32'(gnt), 32'h0);

        // Simultaneous requests right after reset: m0 first, then direct handoff to m1
        rst = 1'b1; step(); rst = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'hA000_0000;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'hB000_0000; m1_we = 1'b1;
        m1_wdat = 32'hCAFE_F00D; m1_sel = 4'h3;
        step();
        chk("t2_gnt0", 32'(gnt), 32'h1);
        chk("t2_adr0", s_adr, 32'hA000_0000);
        s_ack = 1'b1;
        #1;
        chk("t2_m1_noack", 32'(m1_ack), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        step();
        chk("t2_gnt1", 32'(gnt), 32'h2);
        chk("t2_adr1", s_adr, 32'hB000_0000);
        chk("t2_we1", 32'(s_we), 32'h1);
        chk("t2_wdat1", s_wdat, 32'hCAFE_F00D);
        chk("t2_sel1", 32'(s_sel), 32'h3);
        s_ack = 1'b1;
        #1;
        chk("t2_m1_ack", 32'(m1_ack), 32'h1);
        chk("t2_m0_noack", 32'(m0_ack), 32'h0);
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
        step();
        chk("t2_idle", 32'(gnt), 32'h0);

        // Continuous contention, single-beat transactions: grants alternate
        cnt0 = 0; cnt1 = 0; e = 0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i > 0) begin
                if (e == 0) begin m1_cyc = 1'b1; m1_stb = 1'b1; end
                else        begin m0_cyc = 1'b1; m0_stb = 1'b1; end
            end
            chk("t3_gnt", 32'(gnt), (e == 0) ? 32'h1 : 32'h2);
            cnt0 += int'(gnt[0]);
            cnt1 += int'(gnt[1]);
            s_ack = 1'b1;
            #1;
            chk("t3_ack_owner", (e == 0) ? 32'(m0_ack) : 32'(m1_ack), 32'h1);
            chk("t3_ack_other", (e == 0) ? 32'(m1_ack) : 32'(m0_ack), 32'h0);
            if (e == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
            else        begin m1_cyc = 1'b0; m1_stb = 1'b0; end
            s_ack = 1'b0;
            e = 1 - e;
        end
        chk("t3_cnt0", 32'(cnt0), 32'd4);
        chk("t3_cnt1", 32'(cnt1), 32'd4);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        chk("t3_idle", 32'(gnt), 32'h0);

        // m1 holds cyc over 4 beats; m0 waits without ever seeing an ack
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_ack = 1'b1;
            #1;
            chk("t4_gnt_held", 32'(gnt), 32'h2);
            chk("t4_m1_ack", 32'(m1_ack), 32'h1);
            chk("t4_m0_noack", 32'(m0_ack), 32'h0);
            s_ack = 1'b0;
            if (k == 3) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
            step();
        end
        chk("t4_gnt0", 32'(gnt), 32'h1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        chk("t4_idle", 32'(gnt), 32'h0);

        // Reset during an unacked GRANT1 beat, then normal re-arbitration
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        chk("t5_gnt1", 32'(gnt), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_rst_scyc", 32'(s_cyc), 32'h0);
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        step();
        chk("t5_regnt", 32'(gnt), 32'h2);
        chk("t5_regnt_scyc", 32'(s_cyc), 32'h1);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acks: forced err after 4 wait cycles, then IDLE
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("to_wait_err", 32'(m0_err), 32'h0);
            chk("to_wait_scyc", 32'(s_cyc), 32'h1);
            step();
        end
        chk("to_err", 32'(m0_err), 32'h1);
        chk("to_scyc_drop", 32'(s_cyc), 32'h0);
        chk("to_sstb_drop", 32'(s_stb), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        chk("to_idle", 32'(gnt), 32'h0);
        chk("to_err_gone", 32'(m0_err), 32'h0);

        // Ack in the timeout cycle wins
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int k = 0; k < 4; k++) step();
        s_ack = 1'b1;
        #1;
        chk("toack_ack", 32'(m0_ack), 32'h1);
        chk("toack_noerr", 32'(m0_err), 32'h0);
        chk("toack_scyc", 32'(s_cyc), 32'h1);
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        step();
        chk("toack_idle", 32'(gnt), 32'h0);
`else
        // No timeout logic: a stalled slave is waited on indefinitely; err passes straight through
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int k = 0; k < 8; k++) step();
        chk("nto_noerr", 32'(m0_err), 32'h0);
        chk("nto_gnt", 32'(gnt), 32'h1);
        chk("nto_scyc", 32'(s_cyc), 32'h1);
        s_err = 1'b1;
        #1;
        chk("nto_err_pass", 32'(m0_err), 32'h1);
        chk("nto_m1_noerr", 32'(m1_err), 32'h0);
        m0_cyc = 1'b0; m0_stb = 1'b0; s_err = 1'b0;
        step();
        chk("nto_idle", 32'(gnt), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
